wb_bus_arbiter: RTL
===================

// Module: wb_bus_arbiter
// PURPOSE
//  Round-robin arbiter for the node-side shared WISHBONE bus. Drives the gnt_wb_i of each NIC and other
//  bus masters. Grants one CYC-requesting master at a time and holds the grant until that master drops CYC.
//  Optional watchdog revokes a grant that never sees a slave termination.
// PARAMETERS
//  N_MASTERS        4    number of requesting masters (>=2)
//  N_BITS_MASTER_ID 2    clog2(N_MASTERS), width of gnt_id_o
//  TIMEOUT_CYCLES   64   watchdog limit in cycles without termination (used only with WB_ARB_TIMEOUT_EN)
//  N_BITS_TIMEOUT   7    clog2(TIMEOUT_CYCLES+1), watchdog counter width
// PORTS
//  clk         in   1                  clock, all state on rising edge
//  rst         in   1                  asynchronous, active-high reset
//  cyc_i       in   N_MASTERS          CYC of each master; bit i = request from master i
//  term_i      in   1                  slave termination seen on the shared bus (ACK|ERR|RTY)
//  gnt_o       out  N_MASTERS          one-hot grant; to gnt_wb_i of each master
//  gnt_id_o    out  N_BITS_MASTER_ID   index of the granted master; valid when bus_busy_o=1
//  bus_busy_o  out  1                  1 while any grant is held
//  timeout_o   out  1                  1-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  - Reset (async, immediate): gnt_o=0, gnt_id_o=0, bus_busy_o=0, timeout_o=0, state=IDLE,
//    rr pointer=N_MASTERS-1 (master 0 wins first), watchdog count=0, lockout mask=0.
//  - All outputs are registered. gnt_o is one-hot or zero, never multi-hot.
//  - FSM states: IDLE, GRANT, LOCK (LOCK exists only with WB_ARB_TIMEOUT_EN).
//  - IDLE: if any eligible cyc_i=1 at edge t, gnt_o is set at t+1 (1-cycle latency) and state goes to GRANT.
//    Eligible means cyc_i bit=1 and lockout bit=0.
//  - Winner search starts at (ptr+1) mod N_MASTERS and takes the first eligible bit, wrapping from N_MASTERS-1 to 0.
//    On every new grant, ptr=winner.
//  - GRANT: the grant holds while cyc_i[owner]=1, and other requests are ignored.
//    If cyc_i[owner]=0 at edge t, the grant releases at t+1. At the same edge, the grant passes directly to the
//    next eligible requester (zero dead cycles). If there is none, go to IDLE with gnt_o=0.
//  - The owner dropping and re-raising CYC is a new request. If others are waiting, round-robin makes it lose.
//  - cyc_i of non-owners has no effect during GRANT. term_i is used only by the watchdog.
//  - Reset asserted mid-grant drops gnt_o at once. There is no grant memory after reset.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//  - The watchdog counter clears on each new grant and on term_i=1. It increments each GRANT cycle with term_i=0.
//  - When the count reaches TIMEOUT_CYCLES at edge t: at t+1, gnt_o=0, timeout_o=1 for 1 cycle,
//    lockout[owner]=1, state=LOCK.
//  - In LOCK, arbitration proceeds as in IDLE and may grant other masters (LOCK->GRANT).
//  - lockout[i] clears once cyc_i[i]=0 is sampled. When no lockout bit remains set and no grant is held, go to IDLE.
//  - term_i and the count limit in the same cycle: term_i wins and no timeout occurs.
//  WB_ARB_TIMEOUT_EN undefined:
//  - No counter, no LOCK state, lockout mask is constant 0, timeout_o tied 0, TIMEOUT_CYCLES ignored.
// TESTING
//  T1 reset: rst=1 with cyc_i=4'b1111 -> gnt_o=0, bus_busy_o=0, timeout_o=0. Release rst -> gnt_o=4'b0001 one cycle later.
//  T2 latency: idle bus, cyc_i=4'b0100 at edge t -> gnt_o=4'b0100 and gnt_id_o=2 at t+1. Held 10 cycles while cyc_i[2]=1.
//  T3 fairness: cyc_i=4'b1111, each owner drops CYC after 3 cycles then re-raises -> grant order 0,1,2,3,0,
//     zero idle cycles between grants.
//  T4 handoff: owner 1 drops CYC at t with cyc_i[3]=1 -> gnt_o=4'b1000 at t+1. Then cyc_i=0 -> gnt_o=0, IDLE.
//  T5 reset mid-grant: assert rst during owner 2 transfer -> gnt_o=0 same cycle. After release with cyc_i=4'b0100
//     -> master 2 regranted (ptr reset).
//  T6 (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): owner 0 holds CYC, term_i=0 -> gnt dropped after 8 cycles,
//     timeout_o=1 for one cycle, master 1 granted if requesting. Master 0 not regranted until its cyc_i goes 0 then 1.
//     Repeat with term_i=1 every 5 cycles -> no timeout.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter: one CYC-requesting master owns the bus until it drops CYC.
// Optional grant watchdog with lockout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter #(
  parameter int N_MASTERS        = 4,
  parameter int N_BITS_MASTER_ID = 2,
  parameter int TIMEOUT_CYCLES   = 64,
  parameter int N_BITS_TIMEOUT   = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        cyc_i,
  input  logic                        term_i,
  output logic [N_MASTERS-1:0]        gnt_o,
  output logic [N_BITS_MASTER_ID-1:0] gnt_id_o,
  output logic                        bus_busy_o,
  output logic                        timeout_o
);

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_LOCK = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_e;
`endif

  // Returns {found, index} of the first set bit after ptr, wrapping around.
  function automatic logic [N_BITS_MASTER_ID:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                                        input logic [N_BITS_MASTER_ID-1:0] ptr);
    logic                        found;
    logic [N_BITS_MASTER_ID-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      int c;
      c = (int'(ptr) + k) % N_MASTERS;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = N_BITS_MASTER_ID'(c);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  state_e                      state_q, state_d;
  logic [N_MASTERS-1:0]        gnt_q, gnt_d;
  logic [N_BITS_MASTER_ID-1:0] gnt_id_q, gnt_id_d;
  logic                        busy_q, busy_d;
  logic                        timeout_q, timeout_d;
  logic [N_BITS_MASTER_ID-1:0] ptr_q, ptr_d;

  logic [N_MASTERS-1:0]        lock_mask_s;
  logic [N_MASTERS-1:0]        elig_s;
  logic [N_BITS_MASTER_ID:0]   pick_s;
  logic                        win_found_s;
  logic [N_BITS_MASTER_ID-1:0] win_id_s;
  logic                        owner_cyc_s;
  logic                        do_grant_s;
  state_e                      rest_state_s;

`ifdef WB_ARB_TIMEOUT_EN
  logic [N_MASTERS-1:0]      lock_q, lock_d;
  logic [N_BITS_TIMEOUT-1:0] cnt_q, cnt_d;
  assign lock_mask_s = lock_q;
`else
  logic unused_ok_s;
  assign lock_mask_s = '0;
  assign unused_ok_s = ^{term_i, N_BITS_TIMEOUT'(TIMEOUT_CYCLES)};
`endif

  assign elig_s      = cyc_i & ~lock_mask_s;
  assign pick_s      = rr_pick(elig_s, ptr_q);
  assign win_found_s = pick_s[N_BITS_MASTER_ID];
  assign win_id_s    = pick_s[N_BITS_MASTER_ID-1:0];
  assign owner_cyc_s = |(cyc_i & gnt_q);

  // Next-state, grant selection and watchdog.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    do_grant_s = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d  = cnt_q;
    lock_d = lock_q & cyc_i;
    rest_state_s = (lock_d == '0) ? ST_IDLE : ST_LOCK;
`else
    rest_state_s = ST_IDLE;
`endif

    case (state_q)
      ST_GRANT: begin
        if (owner_cyc_s) begin
`ifdef WB_ARB_TIMEOUT_EN
          // term_i has priority over reaching the limit on the same edge.
          if (term_i) begin
            cnt_d = '0;
          end else if (cnt_q == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
            gnt_d     = '0;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            lock_d    = lock_d | gnt_q;
            cnt_d     = '0;
            state_d   = ST_LOCK;
          end else begin
            cnt_d = cnt_q + N_BITS_TIMEOUT'(1);
          end
`else
          state_d = ST_GRANT;
`endif
        end else if (win_found_s) begin
          do_grant_s = 1'b1;
        end else begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = rest_state_s;
        end
      end
      default: begin
        if (win_found_s) begin
          do_grant_s = 1'b1;
        end else begin
          state_d = rest_state_s;
        end
      end
    endcase

    if (do_grant_s) begin
      state_d  = ST_GRANT;
      gnt_d    = N_MASTERS'(1) << win_id_s;
      gnt_id_d = win_id_s;
      ptr_d    = win_id_s;
      busy_d   = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_d    = '0;
`endif
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= N_BITS_MASTER_ID'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      lock_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign gnt_id_o   = gnt_id_q;
  assign bus_busy_o = busy_q;
  assign timeout_o  = timeout_q;

endmodule
